// File: rtl/sram_sampler.sv
// sram_sampler: passive sampler of an asynchronous 8-bit SRAM bus seen on GPIO.
// Synchronizes E/O/address/data, detects read cycles (E=O=0), captures address
// and data once the read has been active for SETTLE_CYCLES synchronized cycles.
// Ports:
//   clk_200      in   sampling clock
//   rst          in   synchronous active-high reset
//   GPIO[35:0]   in   [0]=E_n, [1]=O_n, [15:2]=address, [23:16]=data, rest unused
//   output_ADDR  out  {1'b0, address} of the last capture
//   output_DATA  out  data of the last capture
//   read_signal  out  one-cycle strobe, a new capture is on output_ADDR/DATA
//   count_output out  number of captures, modulo 16
//   LEDR0        out  registered read-active
module sram_sampler #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk_200,
  input  logic        rst,
  input  logic [35:0] GPIO,
  output logic [14:0] output_ADDR,
  output logic [7:0]  output_DATA,
  output logic        read_signal,
  output logic [3:0]  count_output,
  output logic        LEDR0
);

  // E and O reset to 1 (inactive); address and data reset to 0.
  localparam logic [23:0] SYNC_RST    = 24'h000003;
  // settle_cnt value seen on the edge that completes SETTLE_CYCLES active
  // cycles: edge 1 (IDLE->SETTLE) loads 1, so the capture edge sees N-1.
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Spare header pins are deliberately not sampled.
  logic unused_gpio;
  assign unused_gpio = ^GPIO[35:24];

  // Synchronizer: element 0 is the newest sample, the top element feeds logic.
  // All 24 bits share one chain so control and data stay time-aligned.
  logic [SYNC_STAGES-1:0][23:0] sync_q;

  always_ff @(posedge clk_200) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], GPIO[23:0]};
    end
  end

  logic        e_s;
  logic        o_s;
  logic [13:0] a_s;
  logic [7:0]  d_s;
  logic        act;

  assign e_s = sync_q[SYNC_STAGES-1][0];
  assign o_s = sync_q[SYNC_STAGES-1][1];
  assign a_s = sync_q[SYNC_STAGES-1][15:2];
  assign d_s = sync_q[SYNC_STAGES-1][23:16];
  assign act = ~e_s & ~o_s;

  // Read-detect FSM
  state_t     state_q, state_d;
  logic [3:0] settle_cnt_q, settle_cnt_d;
  logic       capture;

  always_ff @(posedge clk_200) begin
    if (rst) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (act) begin
          if (SETTLE_CYCLES == 1) begin
            // A single active cycle already satisfies the settle time.
            capture      = 1'b1;
            state_d      = S_DONE;
            settle_cnt_d = 4'd0;
          end else begin
            state_d      = S_SETTLE;
            settle_cnt_d = 4'd1;
          end
        end
      end
      S_SETTLE: begin
        if (!act) begin
          // Read aborted before settling: nothing captured.
          state_d      = S_IDLE;
          settle_cnt_d = 4'd0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          capture      = 1'b1;
          state_d      = S_DONE;
          settle_cnt_d = 4'd0;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      S_DONE: begin
        // One capture per read; wait for the read to end.
        if (!act) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        settle_cnt_d = 4'd0;
      end
    endcase
  end

  // Capture registers
  logic [14:0] addr_q;
  logic [7:0]  data_q;
  logic [3:0]  count_q;
  logic        strobe_q;
  logic        led_q;

  always_ff @(posedge clk_200) begin
    if (rst) begin
      addr_q   <= 15'd0;
      data_q   <= 8'd0;
      count_q  <= 4'd0;
      strobe_q <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      strobe_q <= capture;
      led_q    <= act;
      if (capture) begin
        addr_q  <= {1'b0, a_s};
        data_q  <= d_s;
        count_q <= count_q + 4'd1;
      end
    end
  end

  assign output_ADDR  = addr_q;
  assign output_DATA  = data_q;
  assign read_signal  = strobe_q;
  assign count_output = count_q;
  assign LEDR0        = led_q;

endmodule

// File: tb/tb_sram_sampler.sv
module tb_sram_sampler;

  logic        clk_200;
  logic        rst;
  logic [35:0] GPIO;
  logic [14:0] output_ADDR;
  logic [7:0]  output_DATA;
  logic        read_signal;
  logic [3:0]  count_output;
  logic        LEDR0;

  sram_sampler #(.SYNC_STAGES(2), .SETTLE_CYCLES(4)) dut (
    .clk_200      (clk_200),
    .rst          (rst),
    .GPIO         (GPIO),
    .output_ADDR  (output_ADDR),
    .output_DATA  (output_DATA),
    .read_signal  (read_signal),
    .count_output (count_output),
    .LEDR0        (LEDR0)
  );

  // 200 MHz
  initial clk_200 = 1'b0;
  always #2.5 clk_200 = ~clk_200;

  // Pin-to-strobe latency in edges: SYNC_STAGES + SETTLE_CYCLES.
  localparam int LAT = 6;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    logic [3:0]  cnt;
    int          cyc;
  } exp_t;

  exp_t       sb_q[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         nstrobe = 0;
  int         npush = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic       prev_strobe = 1'b0;

  always @(posedge clk_200) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk_200);
    #1;
  endtask

  task automatic set_bus(input logic e, input logic o, input logic [13:0] a, input logic [7:0] d);
    GPIO = {12'hABC, d, a, o, e};
  endtask

  // Expected capture for a read whose pins went active at the current cycle.
  task automatic push_exp(input logic [13:0] a, input logic [7:0] d);
    exp_t e;
    exp_cnt = exp_cnt + 4'd1;
    e.addr = {1'b0, a};
    e.data = d;
    e.cnt  = exp_cnt;
    e.cyc  = cyc + LAT;
    sb_q.push_back(e);
    npush++;
  endtask

  task automatic do_read(input logic [13:0] a, input logic [7:0] d, input int len,
                         input bit expect_cap);
    set_bus(1'b0, 1'b0, a, d);
    if (expect_cap) push_exp(a, d);
    cyc_wait(len);
    set_bus(1'b1, 1'b1, a, d);
    cyc_wait(6);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  always @(negedge clk_200) begin
    if (!rst && read_signal) begin
      nstrobe++;
      chk("strobe_single_cycle", {31'd0, prev_strobe}, 32'd0);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none (addr %0h data %0h)",
                 cyc, output_ADDR, output_DATA);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("cap_addr",    {17'd0, output_ADDR},  {17'd0, e.addr});
        chk("cap_data",    {24'd0, output_DATA},  {24'd0, e.data});
        chk("cap_count",   {28'd0, count_output}, {28'd0, e.cnt});
        chk("cap_latency", cyc,                   e.cyc);
      end
    end
    prev_strobe = read_signal;
  end

  int base;

  initial begin
    // Reset held with a read active on the pins.
    rst = 1'b1;
    set_bus(1'b0, 1'b0, 14'h0123, 8'h5A);
    cyc_wait(3);
    chk("rst_addr",   {17'd0, output_ADDR},  32'd0);
    chk("rst_data",   {24'd0, output_DATA},  32'd0);
    chk("rst_strobe", {31'd0, read_signal},  32'd0);
    chk("rst_count",  {28'd0, count_output}, 32'd0);
    chk("rst_led",    {31'd0, LEDR0},        32'd0);
    rst = 1'b0;
    push_exp(14'h0123, 8'h5A);
    cyc_wait(20);
    set_bus(1'b1, 1'b1, 14'h0123, 8'h5A);
    cyc_wait(8);

    // Basic read, 100 ns.
    set_bus(1'b0, 1'b0, 14'b10101010101010, 8'hAB);
    push_exp(14'h2AAA, 8'hAB);
    cyc_wait(10);
    chk("led_during_read", {31'd0, LEDR0}, 32'd1);
    cyc_wait(10);
    set_bus(1'b1, 1'b1, 14'h2AAA, 8'hAB);
    cyc_wait(8);
    chk("basic_count", {28'd0, count_output}, 32'd2);

    // Idle E/O combinations with changing address/data.
    set_bus(1'b0, 1'b1, 14'h1111, 8'h22);
    cyc_wait(16);
    chk("idle01_led", {31'd0, LEDR0}, 32'd0);
    set_bus(1'b1, 1'b0, 14'h0333, 8'h44);
    cyc_wait(16);
    chk("idle10_led", {31'd0, LEDR0}, 32'd0);
    set_bus(1'b1, 1'b1, 14'h0555, 8'h66);
    cyc_wait(16);
    chk("idle11_led",  {31'd0, LEDR0},        32'd0);
    chk("idle_hold_a", {17'd0, output_ADDR},  32'h2AAA);
    chk("idle_hold_d", {24'd0, output_DATA},  32'hAB);
    chk("idle_count",  {28'd0, count_output}, 32'd2);

    // Second read, 80 ns.
    do_read(14'd5678, 8'hCD, 16, 1'b1);
    chk("second_addr",  {17'd0, output_ADDR},  32'h162E);
    chk("second_count", {28'd0, count_output}, 32'd3);

    // Short pulses: 2 and 3 cycles are ignored, 4 cycles is the minimum.
    do_read(14'h0042, 8'h11, 2, 1'b0);
    chk("short2_count", {28'd0, count_output}, 32'd3);
    do_read(14'h0043, 8'h12, 3, 1'b0);
    chk("short3_count", {28'd0, count_output}, 32'd3);
    chk("short3_addr",  {17'd0, output_ADDR},  32'h162E);
    do_read(14'h3FFF, 8'hFF, 4, 1'b1);
    chk("min4_count", {28'd0, count_output}, 32'd4);

    // Reset in the middle of a settle: nothing captured, counter cleared.
    set_bus(1'b0, 1'b0, 14'h0777, 8'h77);
    cyc_wait(4);
    rst = 1'b1;
    set_bus(1'b1, 1'b1, 14'h0777, 8'h77);
    cyc_wait(1);
    rst = 1'b0;
    exp_cnt = 4'd0;
    cyc_wait(12);
    chk("midrst_count", {28'd0, count_output}, 32'd0);
    chk("midrst_addr",  {17'd0, output_ADDR},  32'd0);
    chk("midrst_data",  {24'd0, output_DATA},  32'd0);

    // Wrap: 17 separated reads.
    base = nstrobe;
    for (int i = 0; i < 17; i++) begin
      do_read(14'(i * 100 + 1), 8'(i * 7 + 3), 6, 1'b1);
    end
    chk("wrap_count",   {28'd0, count_output}, 32'd1);
    chk("wrap_strobes", nstrobe - base,        32'd17);

    cyc_wait(10);
    chk("sb_drained",    sb_q.size(), 32'd0);
    chk("total_strobes", nstrobe,     npush);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
